// File: rtl/kernel_pr_wb_start_arbiter.sv
// Round-robin arbiter that lets NREQ PageRank PE lanes share the write_back start-token FIFO.
// It tracks issued-but-not-completed starts and sequences RUN/DRAIN/IDLE so the region can quiesce.
module kernel_pr_wb_start_arbiter #(
    parameter int unsigned NREQ            = 4,
    parameter int unsigned IDX_W           = 2,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic             fifo_full_n,
    output logic             fifo_write,
    output logic             fifo_write_ce,
    output logic [IDX_W-1:0] fifo_din,
    input  logic             done_valid,
    output logic             done_ready,
    output logic [CNT_W-1:0] outstanding,
    output logic             busy,
    output logic             drained,
    output logic [31:0]      total_grants
);

    localparam int unsigned      SUM_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] sel;
    logic [SUM_W-1:0] cand;
    logic             any_req;
    logic             grant_ok;
    logic             grant;
    logic             done_accept;
    logic             drain_done;

    // First requesting lane at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + SUM_W'(k);
            if (cand >= SUM_W'(NREQ)) begin
                cand = cand - SUM_W'(NREQ);
            end
            if (!any_req && req_valid[cand[IDX_W-1:0]]) begin
                any_req = 1'b1;
                sel     = cand[IDX_W-1:0];
            end
        end
    end

    // Grant qualification and zero-latency handshake outputs
    always_comb begin
        grant_ok      = (state == ST_RUN) && enable && fifo_full_n && (outstanding < MAX_CNT);
        grant         = grant_ok && any_req;
        done_ready    = (outstanding != '0);
        done_accept   = done_valid && done_ready;
        fifo_write_ce = 1'b1;
        fifo_write    = grant;
        fifo_din      = grant ? sel : '0;
        req_ready     = grant ? (NREQ'(1) << sel) : '0;
    end

    // Sequencer next-state
    always_comb begin
        state_next = state;
        drain_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_next = ST_RUN;
                end else if (outstanding == '0) begin
                    state_next = ST_IDLE;
                    drain_done = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            drained      <= 1'b0;
            rr_ptr       <= '0;
            outstanding  <= '0;
            total_grants <= '0;
        end else begin
            state   <= state_next;
            busy    <= (state_next != ST_IDLE);
            drained <= drain_done;
            if (grant) begin
                rr_ptr       <= (sel == LAST_IX) ? '0 : sel + IDX_W'(1);
                total_grants <= total_grants + 32'd1;
            end
            // Simultaneous issue and completion leaves the count unchanged
            case ({grant, done_accept})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_pr_wb_start_arbiter.sv
// Directed bench for kernel_pr_wb_start_arbiter: grant order, backpressure, credit limit, drain and reset.
module tb_kernel_pr_wb_start_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [3:0]  req_ready;
    logic        fifo_full_n = 1'b1;
    logic        fifo_write;
    logic        fifo_write_ce;
    logic [1:0]  fifo_din;
    logic        done_valid = 1'b0;
    logic        done_ready;
    logic [7:0]  outstanding;
    logic        busy;
    logic        drained;
    logic [31:0] total_grants;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_total = 32'd0;

    kernel_pr_wb_start_arbiter #(
        .NREQ(4), .IDX_W(2), .MAX_OUTSTANDING(8), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .fifo_full_n(fifo_full_n), .fifo_write(fifo_write),
        .fifo_write_ce(fifo_write_ce), .fifo_din(fifo_din),
        .done_valid(done_valid), .done_ready(done_ready),
        .outstanding(outstanding), .busy(busy), .drained(drained),
        .total_grants(total_grants)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic exp_grant(input string tag, input int lane);
        chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << lane));
        chk({tag, "_write"}, 32'(fifo_write), 32'd1);
        chk({tag, "_din"},   32'(fifo_din),   32'(lane));
        chk({tag, "_total"}, total_grants,    exp_total);
        exp_total = exp_total + 32'd1;
    endtask

    task automatic exp_none(input string tag);
        chk({tag, "_ready"}, 32'(req_ready),  32'd0);
        chk({tag, "_write"}, 32'(fifo_write), 32'd0);
        chk({tag, "_din"},   32'(fifo_din),   32'd0);
    endtask

    initial begin
        // Reset state
        tick(); tick(); settle();
        exp_none("rst");
        chk("rst_out",   32'(outstanding),   32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_drn",   32'(drained),       32'd0);
        chk("rst_total", total_grants,       32'd0);
        chk("rst_ce",    32'(fifo_write_ce), 32'd1);
        chk("rst_dr",    32'(done_ready),    32'd0);
        tick();

        // All lanes requesting, completions always returning
        reset = 1'b0; enable = 1'b1; req_valid = 4'b1111; done_valid = 1'b1;
        settle();
        exp_none("idle_cyc");
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            settle();
            exp_grant("rr_all", k % 4);
            chk("rr_all_out", 32'(outstanding), (k == 0) ? 32'd0 : 32'd1);
            chk("rr_all_busy", 32'(busy), 32'd1);
            tick();
        end

        // Sparse requests 1010 starting from rr_ptr=2
        req_valid = 4'b1010;
        settle(); exp_grant("sparse0", 3); chk("sparse_out", 32'(outstanding), 32'd1); tick();
        settle(); exp_grant("sparse1", 1); tick();
        settle(); exp_grant("sparse2", 3); tick();

        // FIFO full backpressure with lane 2 waiting
        req_valid = 4'b0100; fifo_full_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle(); exp_none("full"); tick();
        end
        chk("full_out", 32'(outstanding), 32'd0);
        fifo_full_n = 1'b1;
        settle(); exp_grant("full_rel", 2); tick();
        req_valid = 4'b0000;
        settle();
        chk("prep_out", 32'(outstanding), 32'd1);
        chk("prep_dr",  32'(done_ready),  32'd1);
        tick();

        // Credit limit: no completions, eight grants then stall
        done_valid = 1'b0; req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            exp_grant("cred", (3 + k) % 4);
            chk("cred_out", 32'(outstanding), 32'(k));
            tick();
        end
        settle(); exp_none("cred_full"); chk("cred_max", 32'(outstanding), 32'd8); tick();
        done_valid = 1'b1;
        settle(); exp_none("cred_done"); chk("cred_dr", 32'(done_ready), 32'd1); tick();
        done_valid = 1'b0;
        settle(); exp_grant("cred_one", 3); chk("cred_7", 32'(outstanding), 32'd7); tick();
        settle(); exp_none("cred_again"); chk("cred_8", 32'(outstanding), 32'd8);
        chk("cred_total", total_grants, exp_total);

        // Retire five completions to reach outstanding=3
        req_valid = 4'b0000; done_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        enable = 1'b0; done_valid = 1'b0; req_valid = 4'b1111;
        settle();
        exp_none("en_fall");
        chk("en_fall_out",  32'(outstanding), 32'd3);
        chk("en_fall_busy", 32'(busy),        32'd1);
        tick();
        settle(); exp_none("drain"); chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_out", 32'(outstanding), 32'd3);
        done_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle(); exp_none("drain_done"); chk("drain_drn0", 32'(drained), 32'd0); tick();
        end
        done_valid = 1'b0;
        settle();
        chk("drain_zero", 32'(outstanding), 32'd0);
        chk("drain_busy1", 32'(busy), 32'd1);
        chk("drain_drn1", 32'(drained), 32'd0);
        tick();
        settle(); chk("idle_busy0", 32'(busy), 32'd0); chk("drained_pulse", 32'(drained), 32'd1); tick();
        settle(); chk("drained_clr", 32'(drained), 32'd0);

        // Reset while running with five outstanding
        enable = 1'b1; req_valid = 4'b1111; done_valid = 1'b0;
        settle(); exp_none("re_idle"); tick();
        for (int k = 0; k < 5; k++) begin
            settle(); exp_grant("re_run", k % 4); tick();
        end
        reset = 1'b1;
        settle();
        chk("pre_rst_out",  32'(outstanding), 32'd5);
        chk("pre_rst_busy", 32'(busy),        32'd1);
        tick();
        reset = 1'b0; enable = 1'b0; done_valid = 1'b1; exp_total = 32'd0;
        settle();
        chk("mid_rst_out",   32'(outstanding), 32'd0);
        chk("mid_rst_busy",  32'(busy),        32'd0);
        chk("mid_rst_total", total_grants,     32'd0);
        chk("mid_rst_dr",    32'(done_ready),  32'd0);
        tick();
        settle(); chk("late_done_out", 32'(outstanding), 32'd0);
        enable = 1'b1; done_valid = 1'b0;
        settle(); exp_none("post_rst_idle"); tick();
        settle(); exp_grant("post_rst_rr", 0); tick();
        settle(); chk("post_rst_total", total_grants, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
